dl_rom_sequencer: RTL
=====================

Name: dl_rom_sequencer

Overview:
- Sequences the HPS ROM download (ioctl stream) into the Defender core's ROM write port (dn_addr/dn_data/dn_wr).
- Owns the core reset: holds the core in reset from power-up until a valid image has loaded, and again during any later reload.
- Re-times writes, drops out-of-range bytes, counts and checksums the image, and flags size errors.
- Sits between hps_io and defender in the emu top, clocked by clk_sys.

Parameters:
- ADDR_W, 16, width of dn_addr.
- ROM_SIZE, 49152, expected image length in bytes; valid addresses are 0..ROM_SIZE-1.
- HOLD_CYCLES, 16, clk_sys cycles the core stays in reset after a download ends; legal range 1..255.

Ports:
- clk_sys  in  1  system clock (24 MHz).
- reset  in  1  synchronous, active-high.
- ioctl_download  in  1  download window active.
- ioctl_wr  in  1  one-cycle write strobe.
- ioctl_addr  in  25  byte address.
- ioctl_dout  in  8  byte data.
- dn_addr  out  ADDR_W  registered write address to the core ROMs.
- dn_data  out  8  registered write data.
- dn_wr  out  1  registered one-cycle write strobe.
- core_reset  out  1  reset request to the core; ORed externally with the user reset.
- rom_valid  out  1  last download completed with the correct size.
- size_err  out  1  last download byte count was not ROM_SIZE.
- ovf_err  out  1  last download contained an address >= ROM_SIZE.
- checksum  out  16  sum mod 2^16 of all accepted bytes in the last download.

Behaviour:
- Clock and reset: one clock, clk_sys. reset is synchronous and active-high.
- Values in reset: state=BOOT, dn_wr=0, dn_addr=0, dn_data=0, core_reset=1, rom_valid=0, size_err=0, ovf_err=0, checksum=0, byte count=0, hold counter=0.
- States (enum in package):
  - BOOT: core_reset=1. ioctl_download=1 -> LOAD.
  - LOAD: core_reset=1. On entry (first cycle ioctl_download seen high), clear count, checksum, size_err, ovf_err and rom_valid. ioctl_download=0 -> SETTLE, and load the hold counter with HOLD_CYCLES-1.
  - SETTLE: core_reset=1; the hold counter decrements. At 0: if count==ROM_SIZE -> RUN with rom_valid=1, else -> BOOT with size_err=1.
  - RUN: core_reset=0. ioctl_download=1 -> LOAD; core_reset rises on the next edge, one cycle of latency.
- Write acceptance:
  - A cycle is a write when ioctl_wr=1 and ioctl_download=1, or when ioctl_wr=1 in the cycle ioctl_download falls. In that falling-edge case the final byte is still accepted before SETTLE.
  - ioctl_wr outside a download is ignored entirely.
- Accepted write with ioctl_addr < ROM_SIZE:
  - Next cycle: dn_wr=1, dn_addr=ioctl_addr[ADDR_W-1:0], dn_data=ioctl_dout.
  - count += 1 and checksum += zero-extended byte, both registered in the same cycle.
  - Latency is exactly 1 cycle. dn_wr is never high for two consecutive cycles unless ioctl_wr was.
- Accepted write with ioctl_addr >= ROM_SIZE: no dn_wr and no count/checksum update. ovf_err is set and stays sticky until the next LOAD entry.
- Counter widths:
  - count is 17 bits and saturates at all-ones; it never wraps.
  - checksum wraps mod 2^16.
- Duplicate addresses are each counted and each written; the last write wins in the core. No dedup.
- Download restarting during SETTLE (ioctl_download=1): return to LOAD, clear stats, core_reset stays 1.
- reset asserted mid-LOAD: everything returns to reset values, state BOOT. A download still in progress re-enters LOAD the next cycle, and bytes already streamed are lost (size_err follows).
- Outputs rom_valid, size_err, ovf_err and checksum hold their values until the next LOAD entry.

Decomposition:
- Package dfndr_pkg: dl_state_t enum {BOOT, LOAD, SETTLE, RUN}; constants DL_COUNT_W=17, DL_CSUM_W=16.
- One natural sub-module, dl_stat_accum: count and checksum accumulator with clear/enable, saturating count. Everything else stays in one module.

Test Plan:
- Power-up: reset 2 cycles, then idle 100 cycles -> core_reset=1, dn_wr=0, rom_valid=0, state BOOT.
- Full load: stream 49152 bytes, addr 0..49151, data = addr[7:0], wr every 4th cycle, then drop download:
  - each dn_wr lands 1 cycle after ioctl_wr with matching addr/data;
  - checksum = 192*32640 mod 65536 = 0xA000;
  - core_reset falls exactly 16 cycles after the download falls;
  - rom_valid=1.
- Short image: 1000 bytes, then end -> after the hold, size_err=1, rom_valid=0, core_reset stays 1 (BOOT).
- Overflow: full image plus one write at 0xC000 data 0x55 -> no dn_wr for that byte, ovf_err=1, count=49152, rom_valid=1.
- Reload from RUN: raise ioctl_download -> core_reset=1 next cycle, rom_valid cleared. A write coincident with the download falling is still forwarded.
- reset mid-LOAD after 500 bytes while the download continues -> state BOOT then LOAD, count restarts at 0, final size_err=1.

Source files
------------

// File: rtl/dfndr_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package    : dfndr_pkg                                               |
// | Description: Shared types and widths for the Defender ROM download   |
// |              sequencer (FSM state enum, statistics widths).          |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
package dfndr_pkg;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    LOAD   = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } dl_state_t;

  // 17 bits covers the 48 KiB image with headroom before saturation.
  localparam int DL_COUNT_W = 17;
  localparam int DL_CSUM_W  = 16;

endpackage
`default_nettype wire

// File: rtl/dl_stat_accum.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : dl_stat_accum                                           |
// | Description: Byte counter and additive checksum for one download.    |
// |              clr_i restarts both totals; en_i adds byte_i. When both |
// |              are high the byte becomes the first byte of the new run.|
// |              The count saturates at all-ones, the checksum wraps.    |
// | Ports      : clk_i, rst_i (sync, active-high), clr_i, en_i,          |
// |              byte_i[7:0], count_o[DL_COUNT_W], csum_o[DL_CSUM_W]     |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module dl_stat_accum
  import dfndr_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clr_i,
  input  logic                  en_i,
  input  logic [7:0]            byte_i,
  output logic [DL_COUNT_W-1:0] count_o,
  output logic [DL_CSUM_W-1:0]  csum_o
);

  logic [DL_COUNT_W-1:0] count_q;
  logic [DL_CSUM_W-1:0]  csum_q;
  logic [DL_COUNT_W-1:0] count_base;
  logic [DL_CSUM_W-1:0]  csum_base;

  // Base values the increment builds on: zero on a clear cycle.
  always_comb begin
    count_base = clr_i ? '0 : count_q;
    csum_base  = clr_i ? '0 : csum_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
      csum_q  <= '0;
    end else if (en_i) begin
      count_q <= (&count_base) ? count_base : count_base + 1'b1;
      csum_q  <= csum_base + DL_CSUM_W'(byte_i);
    end else if (clr_i) begin
      count_q <= '0;
      csum_q  <= '0;
    end
  end

  assign count_o = count_q;
  assign csum_o  = csum_q;

endmodule
`default_nettype wire

// File: rtl/dl_rom_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module     : dl_rom_sequencer                                        |
// | Description: Forwards the HPS ioctl ROM stream to the Defender core  |
// |              ROM write port with one cycle of latency, drops bytes   |
// |              beyond ROM_SIZE, counts/checksums the image and holds   |
// |              the core in reset until a correctly sized image loaded. |
// | Ports      : clk_sys, reset (sync, active-high)                      |
// |              ioctl_download, ioctl_wr, ioctl_addr[25], ioctl_dout[8] |
// |              dn_addr[ADDR_W], dn_data[8], dn_wr                      |
// |              core_reset, rom_valid, size_err, ovf_err, checksum[16]  |
// | Revision   : 1.0 - initial release                                   |
// +----------------------------------------------------------------------+
module dl_rom_sequencer
  import dfndr_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int ROM_SIZE    = 49152,
  parameter int HOLD_CYCLES = 16
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic [ADDR_W-1:0] dn_addr,
  output logic [7:0]        dn_data,
  output logic              dn_wr,
  output logic              core_reset,
  output logic              rom_valid,
  output logic              size_err,
  output logic              ovf_err,
  output logic [15:0]       checksum
);

  localparam logic [24:0]           C_ADDR_LIMIT = 25'(ROM_SIZE);
  localparam logic [DL_COUNT_W-1:0] C_COUNT_OK   = DL_COUNT_W'(ROM_SIZE);
  localparam logic [7:0]            C_HOLD_INIT  = 8'(HOLD_CYCLES - 1);

  dl_state_t             state_q, state_d;
  logic [7:0]            hold_q, hold_d;
  logic [ADDR_W-1:0]     dn_addr_q;
  logic [7:0]            dn_data_q;
  logic                  dn_wr_q;
  logic                  rom_valid_q, size_err_q, ovf_err_q;

  logic                  w_load_entry;
  logic                  w_set_valid;
  logic                  w_set_size_err;
  logic                  w_wr_accept;
  logic                  w_wr_in_range;
  logic                  w_wr_ovf;
  logic [DL_COUNT_W-1:0] w_count;
  logic [DL_CSUM_W-1:0]  w_csum;

  // While in LOAD with ioctl_download low we are in the falling-edge
  // cycle, so a coincident strobe still carries the final byte.
  always_comb begin
    w_wr_accept   = ioctl_wr && (ioctl_download || (state_q == LOAD));
    w_wr_in_range = w_wr_accept && (ioctl_addr < C_ADDR_LIMIT);
    w_wr_ovf      = w_wr_accept && !(ioctl_addr < C_ADDR_LIMIT);
  end

  always_comb begin
    state_d        = state_q;
    hold_d         = hold_q;
    core_reset     = 1'b1;
    w_load_entry   = 1'b0;
    w_set_valid    = 1'b0;
    w_set_size_err = 1'b0;
    case (state_q)
      BOOT: begin
        if (ioctl_download) begin
          state_d      = LOAD;
          w_load_entry = 1'b1;
        end
      end
      LOAD: begin
        if (!ioctl_download) begin
          state_d = SETTLE;
          hold_d  = C_HOLD_INIT;
        end
      end
      SETTLE: begin
        if (ioctl_download) begin
          state_d      = LOAD;
          w_load_entry = 1'b1;
        end else if (hold_q == 8'd0) begin
          if (w_count == C_COUNT_OK) begin
            state_d     = RUN;
            w_set_valid = 1'b1;
          end else begin
            state_d        = BOOT;
            w_set_size_err = 1'b1;
          end
        end else begin
          hold_d = hold_q - 8'd1;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        if (ioctl_download) begin
          state_d      = LOAD;
          w_load_entry = 1'b1;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= BOOT;
      hold_q      <= 8'd0;
      dn_addr_q   <= '0;
      dn_data_q   <= 8'd0;
      dn_wr_q     <= 1'b0;
      rom_valid_q <= 1'b0;
      size_err_q  <= 1'b0;
      ovf_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      dn_wr_q <= w_wr_in_range;
      if (w_wr_in_range) begin
        dn_addr_q <= ioctl_addr[ADDR_W-1:0];
        dn_data_q <= ioctl_dout;
      end

      if (w_load_entry)     rom_valid_q <= 1'b0;
      else if (w_set_valid) rom_valid_q <= 1'b1;

      if (w_load_entry)        size_err_q <= 1'b0;
      else if (w_set_size_err) size_err_q <= 1'b1;

      // An out-of-range byte in the entry cycle belongs to the new image.
      if (w_wr_ovf)          ovf_err_q <= 1'b1;
      else if (w_load_entry) ovf_err_q <= 1'b0;
    end
  end

  dl_stat_accum u_accum (
    .clk_i   (clk_sys),
    .rst_i   (reset),
    .clr_i   (w_load_entry),
    .en_i    (w_wr_in_range),
    .byte_i  (ioctl_dout),
    .count_o (w_count),
    .csum_o  (w_csum)
  );

  assign dn_addr   = dn_addr_q;
  assign dn_data   = dn_data_q;
  assign dn_wr     = dn_wr_q;
  assign rom_valid = rom_valid_q;
  assign size_err  = size_err_q;
  assign ovf_err   = ovf_err_q;
  assign checksum  = w_csum;

endmodule
`default_nettype wire
